// File: rtl/eeprom_ctrl_if.sv
// Host-side request/response bundle for eeprom_ctrl.
// The host drives through master; the controller connects through slave.
interface eeprom_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data, busy, done, err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data, busy, done, err
    );
endinterface

// File: rtl/eeprom_ctrl.sv
// Clocked EEPROM controller: registered reads and timed word program/erase and chip erase.
// Optional write protection is enabled by defining EEPROM_WP_EN.
module eeprom_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int WRITE_CYCLES = 8,
    parameter int ERASE_CYCLES = 16
`ifdef EEPROM_WP_EN
    ,
    parameter int WP_BASE      = (1 << ADDR_W) / 2
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef EEPROM_WP_EN
    input  logic         wp,
`endif
    eeprom_ctrl_if.slave bus
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_CYC = (WRITE_CYCLES > ERASE_CYCLES) ? WRITE_CYCLES : ERASE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t WRITE_LOAD = cnt_t'(WRITE_CYCLES - 1);
    localparam cnt_t ERASE_LOAD = cnt_t'(ERASE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, READ, PROG, ERASE, CHIP_ERASE} state_e;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERASE, OP_CHIP} op_e;

    // The store holds each word XORed with its power-up image, so a cleared
    // store presents the required power-up contents without any reset.
    function automatic logic [DATA_W-1:0] power_up_word(input int idx);
        return DATA_W'(16 + idx);
    endfunction

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              load_req;
    logic              start_read;
    logic              commit;
`ifdef EEPROM_WP_EN
    logic              reject;
    logic              err_q;
`endif

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_req   = 1'b0;
        start_read = 1'b0;
        commit     = 1'b0;
`ifdef EEPROM_WP_EN
        reject     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    load_req = 1'b1;
`ifdef EEPROM_WP_EN
                    // Protected requests are consumed but never leave IDLE.
                    if (wp && ((bus.req_op == OP_CHIP) ||
                               (bus.req_op != OP_READ && int'(bus.req_addr) >= WP_BASE)))
                        reject = 1'b1;
                    else
`endif
                    case (op_e'(bus.req_op))
                        OP_READ: begin
                            state_d    = READ;
                            start_read = 1'b1;
                        end
                        OP_WRITE: begin
                            state_d = PROG;
                            cnt_d   = WRITE_LOAD;
                        end
                        OP_ERASE: begin
                            state_d = ERASE;
                            cnt_d   = ERASE_LOAD;
                        end
                        OP_CHIP: begin
                            state_d = CHIP_ERASE;
                            cnt_d   = ERASE_LOAD;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            READ: state_d = IDLE;
            PROG, ERASE, CHIP_ERASE: begin
                // Commit is atomic on the final busy edge, so an abort leaves the array untouched.
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE);
            if (load_req) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (start_read)
                rd_data_q <= mem_q[bus.req_addr] ^ power_up_word(int'(bus.req_addr));
        end
    end

`ifdef EEPROM_WP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= reject;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // NOTE: the store has no reset branch; its contents must survive rst_n.
    always_ff @(posedge clk) begin
        if (commit) begin
            case (state_q)
                PROG:  mem_q[addr_q] <= wdata_q ^ power_up_word(int'(addr_q));
                ERASE: mem_q[addr_q] <= power_up_word(int'(addr_q));
                CHIP_ERASE: begin
                    for (int i = 0; i < DEPTH; i++)
                        mem_q[i] <= power_up_word(i);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rd_valid  = (state_q == READ);
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = (state_q == PROG) || (state_q == ERASE) || (state_q == CHIP_ERASE);
    assign bus.done      = commit;

endmodule

// File: doc/eeprom_ctrl.md
Name: eeprom_ctrl

Overview:
- Parametrised, clocked successor to the team's small combinational EEPROM model.
- Adds a request/ready handshake, registered reads, and multi-cycle program/erase timing with a busy window.
- Adds single-word and whole-array erase, and an error/done status path.
- Sits between a host sequencer and the on-chip non-volatile store model. The array is not cleared by reset.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- WRITE_CYCLES, 8, clock cycles a word program stays busy (>=1).
- ERASE_CYCLES, 16, clock cycles a word or chip erase stays busy (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  controller can accept a request
- req_op  input  2  00 read, 01 write, 10 word erase, 11 chip erase
- req_addr  input  ADDR_W  target word (ignored for chip erase)
- req_wdata  input  DATA_W  write data
- rd_valid  output  1  one-cycle pulse, rd_data valid
- rd_data  output  DATA_W  read result, held until next read
- busy  output  1  program/erase in progress
- done  output  1  one-cycle pulse when a write or erase commits
- err  output  1  one-cycle pulse on rejected request

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: req_ready=0 while rst_n low, 1 on the first cycle after release. rd_valid=0, rd_data=0, busy=0, done=0, err=0, state=IDLE, counter=0.
- Array contents survive reset.
- Power-up array contents: word i = (16+i) mod 2**DATA_W.
- Erased word value: all zeros.
- FSM states: IDLE, READ, PROG, ERASE, CHIP_ERASE.
- Handshake: req_ready=1 only in IDLE. A request is accepted on a rising edge with req_valid && req_ready. Address, op and data are latched at acceptance; later changes are ignored.
- Read: IDLE->READ on accept. Next cycle: rd_valid=1, rd_data=array[addr], return to IDLE. Latency 1 cycle. Back-to-back reads can be accepted every 2 cycles.
- Write: IDLE->PROG on accept; busy=1 for exactly WRITE_CYCLES cycles.
  - array[addr] is updated on the last busy cycle's edge, with done=1 that same cycle.
  - Then return to IDLE.
- Word erase: same as write, but uses ERASE_CYCLES and the value 0.
- Chip erase: CHIP_ERASE for ERASE_CYCLES cycles; all DEPTH words zeroed at commit; done pulse.
- Counter: loads N-1 on accept and decrements to 0. Width = clog2(max(WRITE_CYCLES,ERASE_CYCLES)+1).
- req_valid while busy: not accepted, not an error. The host must hold the request until req_ready.
- Reset mid-operation: the operation is aborted and the target word(s) keep their pre-request value. This holds because commit is atomic at the final cycle. Outputs return to reset values.
- Address wrap: not applicable; req_addr covers exactly DEPTH.
- Reads never observe a partial program; reads are impossible while busy.

Optional Feature:
- Macro EEPROM_WP_EN.
- Defined: adds input wp (1 bit) and parameter WP_BASE (default 2**ADDR_W/2).
  - Write or word erase with wp=1 and req_addr >= WP_BASE is accepted, stays in IDLE, pulses err=1 next cycle, and leaves the array unchanged.
  - Chip erase with wp=1 is rejected the same way.
  - Reads are never blocked.
- Undefined: no wp port, no WP_BASE parameter, and err is tied to 0.

Test Plan:
- After reset, read addr 3 -> rd_valid one cycle after accept, rd_data=0x13; req_ready low for exactly 1 cycle.
- Write 0xA5 to addr 7 (WRITE_CYCLES=8) -> busy high exactly 8 cycles, done on 8th; then read addr 7 -> 0xA5, addr 6 still 0x16.
- Word erase addr 2, then chip erase (ERASE_CYCLES=16) -> busy 16 cycles each; all 16 reads return 0x00 afterwards.
- Write 0x3C to addr 5 and assert rst_n low on busy cycle 4 -> all outputs reset; read addr 5 returns 0x15.
- Issue a read request while busy -> not accepted until req_ready; read then completes with the committed write value.
- With EEPROM_WP_EN, wp=1: write 0xFF to addr 12 -> err pulse, busy never set, addr 12 reads 0x1C. Write to addr 4 -> succeeds.
